// File: rtl/booth_mul.sv
// booth_mul: sequential signed 16x16 multiplier, radix-2 Booth, one step per clock.
// A start accepted in IDLE or DONE latches a and b and runs 16 Booth steps in CALC.
// The 32-bit product and its Z/N/V/C flags are then registered, and done_mul pulses
// for the one DONE cycle.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, a, b        one-cycle request with signed operands
//   result, result_hi  product[15:0], product[31:16] (held until the next completion)
//   done_mul, busy     completion pulse, high while in CALC
//   Z, N, V, C         zero, sign, does-not-fit-in-16-bits, carry (equal to V)
module booth_mul (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] result,
   output logic [15:0] result_hi,
   output logic        done_mul,
   output logic        busy,
   output logic        Z,
   output logic        N,
   output logic        V,
   output logic        C
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [16:0] acc_q, acc_d;
   logic [16:0] m_q, m_d;
   logic [15:0] q_q, q_d;
   logic        q1_q, q1_d;
   logic [31:0] prod_q, prod_d;
   logic        done_q, done_d, busy_q, busy_d;
   logic        z_q, z_d, n_q, n_d, v_q, v_d;

   logic [16:0] sum;
   logic [16:0] acc_sh;
   logic [15:0] q_sh;
   logic [31:0] prod_new;

   // One Booth step. A is 17 bits wide, so +/-32768 multiples never overflow.
   always_comb begin
      unique case ({q_q[0], q1_q})
         2'b01:   sum = acc_q + m_q;
         2'b10:   sum = acc_q - m_q;
         default: sum = acc_q;
      endcase
      acc_sh   = {sum[16], sum[16:1]};
      q_sh     = {sum[0], q_q[15:1]};
      prod_new = {acc_sh[15:0], q_sh};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      m_d     = m_q;
      q_d     = q_q;
      q1_d    = q1_q;
      prod_d  = prod_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      z_d     = z_q;
      n_d     = n_q;
      v_d     = v_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               m_d     = {a[15], a};
               q_d     = b;
               acc_d   = '0;
               q1_d    = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            acc_d = acc_sh;
            q_d   = q_sh;
            q1_d  = q_q[0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
               // 16th step: commit product and flags together.
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               prod_d  = prod_new;
               z_d     = (prod_new == 32'd0);
               n_d     = prod_new[31];
               v_d     = !((&prod_new[31:15]) || !(|prod_new[31:15]));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         m_q     <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         prod_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         z_q     <= 1'b1;
         n_q     <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         prod_q  <= prod_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         z_q     <= z_d;
         n_q     <= n_d;
         v_q     <= v_d;
      end
   end

   assign result    = prod_q[15:0];
   assign result_hi = prod_q[31:16];
   assign done_mul  = done_q;
   assign busy      = busy_q;
   assign Z         = z_q;
   assign N         = n_q;
   assign V         = v_q;
   assign C         = v_q;
endmodule

// File: tb/tb_booth_mul.sv
module tb_booth_mul;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [15:0] result, result_hi;
   logic        done_mul, busy, Z, N, V, C;

   int n_cmp = 0;
   int n_bad = 0;

   booth_mul dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .result(result), .result_hi(result_hi), .done_mul(done_mul), .busy(busy),
      .Z(Z), .N(N), .V(V), .C(C)
   );

   always #5 clk = ~clk;

   // Drive one operation and wait (bounded) for done_mul. lat counts negedges
   // after the accepting edge; returns in the DONE cycle. With b2b set the start
   // is raised immediately (caller is already in a DONE cycle).
   task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input bit b2b,
                        output int lat, output bit held_bad, output bit busy_bad);
      logic [15:0] r0, h0;
      if (!b2b) @(negedge clk);
      a = ia; b = ib; start = 1'b1;
      r0 = result; h0 = result_hi;
      @(negedge clk);
      start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
      lat = 0; held_bad = 1'b0; busy_bad = 1'b0;
      while (!done_mul && lat < 40) begin
         if (busy !== 1'b1) busy_bad = 1'b1;
         if (result !== r0 || result_hi !== h0) held_bad = 1'b1;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      start = 1'b1; a = 16'h0003; b = 16'h0005;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (result !== 16'h0) begin n_bad++; $display("FAIL rst_result got %h want 0000", result); end
      n_cmp++; if (result_hi !== 16'h0) begin n_bad++; $display("FAIL rst_hi got %h want 0000", result_hi); end
      n_cmp++; if ({done_mul, busy, Z, N, V, C} !== 6'b001000) begin n_bad++; $display("FAIL rst_flags got %b want 001000", {done_mul, busy, Z, N, V, C}); end
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_start_not_accepted busy got %b want 0", busy); end
   endtask

   task automatic test_basic;
      int lat; bit hb, bb;
      do_op(16'h0003, 16'h0005, 1'b0, lat, hb, bb);
      n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL 3x5_latency got %0d want 16", lat); end
      n_cmp++; if ({result_hi, result} !== 32'h0000000F) begin n_bad++; $display("FAIL 3x5_product got %h%h want 0000000f", result_hi, result); end
      n_cmp++; if ({Z, N, V, C} !== 4'b0000) begin n_bad++; $display("FAIL 3x5_flags got %b want 0000", {Z, N, V, C}); end
      n_cmp++; if (bb !== 1'b0 || hb !== 1'b0) begin n_bad++; $display("FAIL 3x5_busy_hold got busy_bad=%b held_bad=%b want 0 0", bb, hb); end
      @(negedge clk);
      n_cmp++; if ({done_mul, busy} !== 2'b00) begin n_bad++; $display("FAIL done_one_cycle got %b want 00", {done_mul, busy}); end
      do_op(16'hFFF9, 16'h0006, 1'b0, lat, hb, bb);
      n_cmp++; if ({result_hi, result} !== 32'hFFFFFFD6) begin n_bad++; $display("FAIL m7x6_product got %h%h want ffffffd6", result_hi, result); end
      n_cmp++; if ({Z, N, V, C} !== 4'b0100) begin n_bad++; $display("FAIL m7x6_flags got %b want 0100", {Z, N, V, C}); end
      n_cmp++; if (hb !== 1'b0) begin n_bad++; $display("FAIL m7x6_result_held got %b want 0", hb); end
   endtask

   task automatic test_boundary;
      int lat; bit hb, bb;
      do_op(16'h8000, 16'h8000, 1'b0, lat, hb, bb);
      n_cmp++; if ({result_hi, result} !== 32'h40000000) begin n_bad++; $display("FAIL min_x_min_product got %h%h want 40000000", result_hi, result); end
      n_cmp++; if ({Z, N, V, C} !== 4'b0011) begin n_bad++; $display("FAIL min_x_min_flags got %b want 0011", {Z, N, V, C}); end
      do_op(16'h7FFF, 16'h7FFF, 1'b0, lat, hb, bb);
      n_cmp++; if ({result_hi, result} !== 32'h3FFF0001) begin n_bad++; $display("FAIL max_x_max_product got %h%h want 3fff0001", result_hi, result); end
      n_cmp++; if ({Z, N, V, C} !== 4'b0011) begin n_bad++; $display("FAIL max_x_max_flags got %b want 0011", {Z, N, V, C}); end
      do_op(16'h8000, 16'h0001, 1'b0, lat, hb, bb);
      n_cmp++; if ({result_hi, result} !== 32'hFFFF8000) begin n_bad++; $display("FAIL min_x_1_product got %h%h want ffff8000", result_hi, result); end
      n_cmp++; if ({Z, N, V, C} !== 4'b0100) begin n_bad++; $display("FAIL min_x_1_flags got %b want 0100", {Z, N, V, C}); end
      do_op(16'h8000, 16'hFFFF, 1'b0, lat, hb, bb);
      n_cmp++; if ({result_hi, result} !== 32'h00008000) begin n_bad++; $display("FAIL min_x_m1_product got %h%h want 00008000", result_hi, result); end
      n_cmp++; if ({Z, N, V, C} !== 4'b0011) begin n_bad++; $display("FAIL min_x_m1_flags got %b want 0011", {Z, N, V, C}); end
      do_op(16'h0000, 16'h1234, 1'b0, lat, hb, bb);
      n_cmp++; if ({result_hi, result} !== 32'h00000000) begin n_bad++; $display("FAIL zero_product got %h%h want 00000000", result_hi, result); end
      n_cmp++; if ({Z, N, V, C} !== 4'b1000) begin n_bad++; $display("FAIL zero_flags got %b want 1000", {Z, N, V, C}); end
      do_op(16'hFFFF, 16'hFFFF, 1'b0, lat, hb, bb);
      n_cmp++; if ({result_hi, result} !== 32'h00000001) begin n_bad++; $display("FAIL m1_x_m1_product got %h%h want 00000001", result_hi, result); end
      n_cmp++; if ({Z, N, V, C} !== 4'b0000) begin n_bad++; $display("FAIL m1_x_m1_flags got %b want 0000", {Z, N, V, C}); end
   endtask

   task automatic test_busy_ignore;
      int dones, first;
      dones = 0; first = -1;
      @(negedge clk);
      a = 16'h0002; b = 16'h0003; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done_mul) begin dones++; if (first < 0) first = k; end
         if (k == 4) begin start = 1'b1; a = 16'h0009; b = 16'h0009; end
         if (k == 5) start = 1'b0;
         if (first < 0 && result !== 16'h0001) begin
            n_cmp++; n_bad++; $display("FAIL ignore_result_changed_in_calc got %h want 0001", result);
         end
         @(negedge clk);
      end
      n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL ignore_done_count got %0d want 1", dones); end
      n_cmp++; if (first !== 16) begin n_bad++; $display("FAIL ignore_latency got %0d want 16", first); end
      n_cmp++; if ({result_hi, result} !== 32'h00000006) begin n_bad++; $display("FAIL ignore_product got %h%h want 00000006", result_hi, result); end
   endtask

   task automatic test_back_to_back;
      int lat; bit hb, bb;
      do_op(16'h0007, 16'h0003, 1'b0, lat, hb, bb);
      n_cmp++; if ({result_hi, result} !== 32'h00000015) begin n_bad++; $display("FAIL b2b_first_product got %h%h want 00000015", result_hi, result); end
      // Start raised during the DONE cycle, accepted at the following edge.
      do_op(16'h0004, 16'h0004, 1'b1, lat, hb, bb);
      n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL b2b_latency got %0d want 16", lat); end
      n_cmp++; if ({result_hi, result} !== 32'h00000010) begin n_bad++; $display("FAIL b2b_second_product got %h%h want 00000010", result_hi, result); end
      n_cmp++; if (bb !== 1'b0 || hb !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_hold got busy_bad=%b held_bad=%b want 0 0", bb, hb); end
   endtask

   task automatic test_mid_reset;
      int lat, dones; bit hb, bb;
      dones = 0;
      @(negedge clk);
      a = 16'h0005; b = 16'h0007; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      n_cmp++; if ({result_hi, result} !== 32'h0) begin n_bad++; $display("FAIL midrst_product got %h%h want 00000000", result_hi, result); end
      n_cmp++; if ({done_mul, busy, Z, N, V, C} !== 6'b001000) begin n_bad++; $display("FAIL midrst_flags got %b want 001000", {done_mul, busy, Z, N, V, C}); end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 2) rst = 1'b0;
         if (done_mul) dones++;
      end
      n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL midrst_no_done got %0d want 0", dones); end
      do_op(16'h000A, 16'hFFF6, 1'b0, lat, hb, bb);
      n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL midrst_next_latency got %0d want 16", lat); end
      n_cmp++; if ({result_hi, result} !== 32'hFFFFFF9C) begin n_bad++; $display("FAIL midrst_next_product got %h%h want ffffff9c", result_hi, result); end
      n_cmp++; if ({Z, N, V, C} !== 4'b0100) begin n_bad++; $display("FAIL midrst_next_flags got %b want 0100", {Z, N, V, C}); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_boundary;
      test_busy_ignore;
      test_back_to_back;
      test_mid_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
